// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle CPU: FSM states, opcodes, ALUOp codes
// and datapath mux selects. Used by the controller, datapath and ALU control.
package mc_pkg;

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMRD    = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWR    = 4'd5;
    localparam logic [3:0] EXEC     = 4'd6;
    localparam logic [3:0] RTYPE_WB = 4'd7;
    localparam logic [3:0] BRANCH   = 4'd8;
    localparam logic [3:0] JUMP     = 4'd9;
    localparam logic [3:0] ADDI_EX  = 4'd10;
    localparam logic [3:0] ADDI_WB  = 4'd11;
    localparam logic [3:0] ILLEGAL  = 4'd12;
    localparam logic [3:0] MEMERR   = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_FUNCT = 4'b1111;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-state counter with timeout compare; only built when
// MEM_TIMEOUT_EN is defined.
module mc_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic count_en_i,
    output logic timeout_o
);

    localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i && (cnt_q != CNT_W'(WAIT_MAX))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the wait cycle that would bring the count up to WAIT_MAX.
    assign timeout_o = count_en_i && (cnt_q == CNT_W'(WAIT_MAX - 1));

endmodule

// File: rtl/mc_controller_hs.sv
// Multicycle CPU control FSM with memory ready handshake, addi/bne and
// illegal-opcode trap. Define MEM_TIMEOUT_EN to add the memory wait timeout.
module mc_controller_hs
    import mc_pkg::*;
#(
    parameter int STATE_W  = 4,
    parameter int ALUOP_W  = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instr_in,
    input  logic               mem_ready,
    input  logic               zero,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               ALUSrcA,
    output logic               RegWrite,
    output logic               RegDst,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [STATE_W-1:0] state,
    output logic [STATE_W-1:0] next_state,
    output logic               illegal_instr,
    output logic               mem_error
);

    logic [3:0] state_q, state_d;
    logic [5:0] opcode;
    logic       timeout;
    ctrl_t      ctrl;

    assign opcode = instr_in[31:26];

    logic unused_instr;
    assign unused_instr = ^instr_in[25:0];

`ifdef MEM_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;

    logic in_wait_state;
    logic mem_error_q;

    assign in_wait_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);

    mc_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (state_d != state_q),
        .count_en_i (in_wait_state && !mem_ready),
        .timeout_o  (timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_error_q <= 1'b0;
        end else if (state_d == MEMERR) begin
            mem_error_q <= 1'b1;
        end
    end

    assign mem_error = mem_error_q && !reset;
`else
    localparam bit TIMEOUT_EN = 1'b0;

    logic unused_wait_max;
    assign unused_wait_max = ^WAIT_MAX;
    assign timeout         = 1'b0;
    assign mem_error       = 1'b0;
`endif

    always_comb begin
        state_d = FETCH;
        if (!reset) begin
            case (state_q)
                FETCH:    state_d = mem_ready ? DECODE : (timeout ? MEMERR : FETCH);
                DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW:   state_d = MEMADR;
                        OP_RTYPE:       state_d = EXEC;
                        OP_BEQ, OP_BNE: state_d = BRANCH;
                        OP_J:           state_d = JUMP;
                        OP_ADDI:        state_d = ADDI_EX;
                        default:        state_d = ILLEGAL;
                    endcase
                end
                MEMADR:   state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
                MEMRD:    state_d = mem_ready ? MEMWB : (timeout ? MEMERR : MEMRD);
                MEMWR:    state_d = mem_ready ? FETCH : (timeout ? MEMERR : MEMWR);
                EXEC:     state_d = RTYPE_WB;
                ADDI_EX:  state_d = ADDI_WB;
                MEMERR:   state_d = TIMEOUT_EN ? MEMERR : FETCH;
                default:  state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore decode, except the FETCH strobes and bne PC write, which are gated by inputs.
    always_comb begin
        ctrl = CTRL_IDLE;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.pc_source = PCSRC_ALU;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                DECODE: begin
                    ctrl.alu_src_b = SRCB_IMM_SH2;
                    ctrl.alu_op    = ALU_ADD;
                end
                MEMADR, ADDI_EX: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALU_ADD;
                end
                MEMRD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.iord     = 1'b1;
                end
                MEMWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                MEMWR: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.iord      = 1'b1;
                end
                EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.alu_op    = ALU_FUNCT;
                end
                RTYPE_WB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                end
                BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_REG;
                    ctrl.alu_op        = ALU_SUB;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                    ctrl.pc_write_cond = (opcode == OP_BEQ);
                    ctrl.pc_write      = (opcode == OP_BNE) && !zero;
                end
                JUMP: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_JUMP;
                end
                ADDI_WB:  ctrl.reg_write = 1'b1;
                ILLEGAL:  ctrl.illegal   = 1'b1;
                default:  ctrl = CTRL_IDLE;
            endcase
        end
    end

    assign PCWrite       = ctrl.pc_write;
    assign PCWriteCond   = ctrl.pc_write_cond;
    assign IorD          = ctrl.iord;
    assign MemRead       = ctrl.mem_read;
    assign MemWrite      = ctrl.mem_write;
    assign IRWrite       = ctrl.ir_write;
    assign MemtoReg      = ctrl.mem_to_reg;
    assign ALUSrcA       = ctrl.alu_src_a;
    assign RegWrite      = ctrl.reg_write;
    assign RegDst        = ctrl.reg_dst;
    assign PCSource      = ctrl.pc_source;
    assign ALUSrcB       = ctrl.alu_src_b;
    assign ALUOp         = ALUOP_W'(ctrl.alu_op);
    assign illegal_instr = ctrl.illegal;
    assign state         = STATE_W'(state_q);
    assign next_state    = STATE_W'(state_d);

endmodule

// File: tb/tb_mc_controller_hs.sv
// Randomized bench for mc_controller_hs: an instruction-level model predicts
// the state trace and per-instruction strobe counts. MEM_TIMEOUT_EN adds the timeout test.
module tb_mc_controller_hs;

    localparam int S_FETCH  = 0;
    localparam int S_DECODE = 1;
    localparam int S_MEMADR = 2;
    localparam int S_MEMRD  = 3;
    localparam int S_MEMWB  = 4;
    localparam int S_MEMWR  = 5;
    localparam int S_EXEC   = 6;
    localparam int S_RTWB   = 7;
    localparam int S_BRANCH = 8;
    localparam int S_JUMP   = 9;
    localparam int S_ADDIEX = 10;
    localparam int S_ADDIWB = 11;
    localparam int S_ILL    = 12;
    localparam int S_MEMERR = 13;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_in;
    logic        mem_ready, zero;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, ALUSrcA, RegWrite, RegDst;
    logic [1:0]  PCSource, ALUSrcB;
    logic [3:0]  ALUOp, state, next_state;
    logic        illegal_instr, mem_error;
    logic [19:0] out_vec;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mc_controller_hs #(
        .STATE_W  (4),
        .ALUOP_W  (4),
        .WAIT_MAX (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_in      (instr_in),
        .mem_ready     (mem_ready),
        .zero          (zero),
        .PCWrite       (PCWrite),
        .PCWriteCond   (PCWriteCond),
        .IorD          (IorD),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .MemtoReg      (MemtoReg),
        .ALUSrcA       (ALUSrcA),
        .RegWrite      (RegWrite),
        .RegDst        (RegDst),
        .PCSource      (PCSource),
        .ALUSrcB       (ALUSrcB),
        .ALUOp         (ALUOp),
        .state         (state),
        .next_state    (next_state),
        .illegal_instr (illegal_instr),
        .mem_error     (mem_error)
    );

    assign out_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                      ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp,
                      illegal_instr, mem_error};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic drive(input bit r, input logic [31:0] ins, input bit rdy, input bit z);
        reset     = r;
        instr_in  = ins;
        mem_ready = rdy;
        zero      = z;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op == LW || op == SW || op == RT || op == BEQ || op == BNE ||
               op == JMP || op == ADDI;
    endfunction

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            drive(1'b1, $urandom, 1'b1, 1'($urandom));
            check("rst_outputs", out_vec, 0);
            check("rst_next_state", next_state, S_FETCH);
            if (i > 0) check("rst_state", state, S_FETCH);
            tick();
        end
    endtask

    // Runs one instruction: wf FETCH wait cycles, wm wait cycles in the memory phase.
    task automatic run_instr(input logic [31:0] ins, input bit z, input int wf, input int wm);
        int st_q[$];
        bit rdy_q[$];
        logic [5:0] op;
        bit is_lw, is_sw, is_rt, is_beq, is_bne, is_j, is_addi, is_ill;
        int c_pcw, c_pcwc, c_irw, c_rw, c_mw, c_mr, c_ill;
        int exp_src;
        op      = ins[31:26];
        is_lw   = (op == LW);
        is_sw   = (op == SW);
        is_rt   = (op == RT);
        is_beq  = (op == BEQ);
        is_bne  = (op == BNE);
        is_j    = (op == JMP);
        is_addi = (op == ADDI);
        is_ill  = !is_legal(op);
        c_pcw = 0; c_pcwc = 0; c_irw = 0; c_rw = 0; c_mw = 0; c_mr = 0; c_ill = 0;

        for (int k = 0; k < wf; k++) begin st_q.push_back(S_FETCH); rdy_q.push_back(1'b0); end
        st_q.push_back(S_FETCH);  rdy_q.push_back(1'b1);
        st_q.push_back(S_DECODE); rdy_q.push_back(1'($urandom));
        if (is_lw || is_sw) begin
            st_q.push_back(S_MEMADR); rdy_q.push_back(1'($urandom));
            for (int k = 0; k < wm; k++) begin
                st_q.push_back(is_lw ? S_MEMRD : S_MEMWR); rdy_q.push_back(1'b0);
            end
            st_q.push_back(is_lw ? S_MEMRD : S_MEMWR); rdy_q.push_back(1'b1);
            if (is_lw) begin st_q.push_back(S_MEMWB); rdy_q.push_back(1'($urandom)); end
        end else if (is_rt) begin
            st_q.push_back(S_EXEC); st_q.push_back(S_RTWB);
            rdy_q.push_back(1'($urandom)); rdy_q.push_back(1'($urandom));
        end else if (is_beq || is_bne) begin
            st_q.push_back(S_BRANCH); rdy_q.push_back(1'($urandom));
        end else if (is_j) begin
            st_q.push_back(S_JUMP); rdy_q.push_back(1'($urandom));
        end else if (is_addi) begin
            st_q.push_back(S_ADDIEX); st_q.push_back(S_ADDIWB);
            rdy_q.push_back(1'($urandom)); rdy_q.push_back(1'($urandom));
        end else begin
            st_q.push_back(S_ILL); rdy_q.push_back(1'($urandom));
        end

        foreach (st_q[i]) begin
            drive(1'b0, ins, rdy_q[i], z);
            check("state", state, st_q[i]);
            check("next_state", next_state, (i + 1 < st_q.size()) ? st_q[i+1] : S_FETCH);
            c_pcw  += int'(PCWrite);
            c_pcwc += int'(PCWriteCond);
            c_irw  += int'(IRWrite);
            c_rw   += int'(RegWrite);
            c_mw   += int'(MemWrite);
            c_mr   += int'(MemRead);
            c_ill  += int'(illegal_instr);
            if (RegWrite) begin
                check("wb_memtoreg", MemtoReg, is_lw);
                check("wb_regdst", RegDst, is_rt);
            end
            if (MemWrite) check("wr_iord", IorD, 1);
            if (PCWrite || PCWriteCond) begin
                exp_src = (st_q[i] == S_BRANCH) ? 1 : (st_q[i] == S_JUMP) ? 2 : 0;
                check("pcsource", PCSource, exp_src);
            end
            if (IRWrite) check("fetch_alu", {IorD, ALUSrcA, ALUSrcB, ALUOp}, 8'b0001_0010);
            tick();
        end

        check("cnt_irwrite", c_irw, 1);
        check("cnt_pcwrite", c_pcw, 1 + int'(is_j) + int'(is_bne && !z));
        check("cnt_pcwritecond", c_pcwc, int'(is_beq));
        check("cnt_regwrite", c_rw, int'(is_lw || is_rt || is_addi));
        check("cnt_memwrite", c_mw, is_sw ? wm + 1 : 0);
        check("cnt_memread", c_mr, wf + 1 + (is_lw ? wm + 1 : 0));
        check("cnt_illegal", c_ill, int'(is_ill));
        check("no_mem_error", mem_error, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  op;
        logic [31:0] ins;
        reset     = 1'b1;
        instr_in  = '0;
        mem_ready = 1'b0;
        zero      = 1'b0;
        tick();
        do_reset(3);

        run_instr({JMP, 26'h0000010}, 1'b0, 0, 0);
        run_instr(32'h8C220004, 1'b0, 2, 3);
        run_instr(32'hAC220008, 1'b0, 0, 0);
        run_instr({BNE, 26'h0221000}, 1'b0, 0, 0);
        run_instr({BNE, 26'h0221000}, 1'b1, 0, 0);
        run_instr({BEQ, 26'h0221000}, 1'b1, 0, 0);
        run_instr({BEQ, 26'h0221000}, 1'b0, 0, 0);
        run_instr({6'b111111, 26'h0}, 1'b0, 0, 0);
        run_instr({RT, 26'h0430020}, 1'b0, 1, 0);
        run_instr({ADDI, 26'h0220005}, 1'b0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 7))
                0: op = LW;
                1: op = SW;
                2: op = RT;
                3: op = BEQ;
                4: op = BNE;
                5: op = JMP;
                6: op = ADDI;
                default: begin
                    do op = 6'($urandom); while (is_legal(op));
                end
            endcase
            ins = {op, 26'($urandom)};
            run_instr(ins, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset while a store is waiting for memory: no write strobe in the reset cycle.
        drive(1'b0, 32'hAC220008, 1'b1, 1'b0);
        check("mid_fetch", state, S_FETCH);
        tick();
        drive(1'b0, 32'hAC220008, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'hAC220008, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'hAC220008, 1'b0, 1'b0);
        check("mid_state", state, S_MEMWR);
        check("mid_memwrite", MemWrite, 1);
        tick();
        drive(1'b1, 32'hAC220008, 1'b1, 1'b0);
        check("mid_rst_outputs", out_vec, 0);
        check("mid_rst_next", next_state, S_FETCH);
        tick();
        drive(1'b0, 32'hAC220008, 1'b0, 1'b0);
        check("mid_after_state", state, S_FETCH);
        check("mid_after_memwrite", MemWrite, 0);
        tick();

`ifdef MEM_TIMEOUT_EN
        drive(1'b0, 32'h8C220004, 1'b1, 1'b0);
        check("to_fetch", state, S_FETCH);
        tick();
        drive(1'b0, 32'h8C220004, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h8C220004, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 32'h8C220004, 1'b0, 1'b0);
            check("to_memrd", state, S_MEMRD);
            check("to_next", next_state, (k == 3) ? S_MEMERR : S_MEMRD);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h8C220004, 1'($urandom), 1'b0);
            check("to_memerr", state, S_MEMERR);
            check("to_outputs", out_vec, 20'h1);
            tick();
        end
        drive(1'b1, 32'h8C220004, 1'b0, 1'b0);
        check("to_rst_err", mem_error, 0);
        tick();
        drive(1'b0, 32'h8C220004, 1'b0, 1'b0);
        check("to_after_state", state, S_FETCH);
        check("to_after_err", mem_error, 0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
